// File: rtl/extractor_stream.sv
// extractor_stream: streams a WIDTH-bit word as LANES-bit beats over valid/ready, LSB or MSB chunk first
module extractor_stream #(
  parameter int WIDTH = 12,
  parameter int LANES = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int BEATS = (WIDTH + LANES - 1) / LANES,
  localparam int IW = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy
);
  localparam int PW = BEATS * LANES;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [IW-1:0] cnt, cnt_n, sel;
  logic [PW-1:0] word;
  logic load, last, out_hs;
  assign busy = state == SHIFT;
  assign last = busy && cnt == IW'(BEATS - 1);
  assign sel = MSB_FIRST ? IW'(BEATS - 1) - cnt : cnt;
  assign out_valid = busy;
  assign out_last = last;
  assign out_idx = busy ? sel : '0;
  assign out_data = busy ? word[sel*LANES +: LANES] : '0;
  assign in_ready = !rst && !flush && (!busy || (last && out_ready));
  assign load = in_valid && in_ready;
  assign out_hs = busy && out_ready;
  always_comb begin
    state_n = flush ? IDLE : load ? SHIFT : (out_hs && last) ? IDLE : state;
    cnt_n = (out_hs && !last && !flush) ? cnt + 1'b1 : (flush || load || out_hs) ? '0 : cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      word <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (load) word <= PW'(in_data);
    end
  end
endmodule

// File: tb/tb_extractor_stream.sv
// tb_extractor_stream: scoreboard bench over four parameterisations of extractor_stream
module tb_extractor_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic ordy = 1'b0;
  logic [11:0] id = '0;
  logic [3:0] iv = '0;
  logic [3:0] ir, ov, ol, bz;
  logic [1:0] oi [4];
  logic [3:0] od_a, od_b;
  logic [4:0] od_c, od_d;
  logic [4:0] od [4];
  logic [7:0] q [4][$];
  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  assign od[0] = {1'b0, od_a};
  assign od[1] = {1'b0, od_b};
  assign od[2] = od_c;
  assign od[3] = od_d;

  extractor_stream #(.WIDTH(12), .LANES(4), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id),
    .out_valid(ov[0]), .out_ready(ordy), .out_data(od_a), .out_idx(oi[0]), .out_last(ol[0]), .busy(bz[0]));
  extractor_stream #(.WIDTH(12), .LANES(4), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id),
    .out_valid(ov[1]), .out_ready(ordy), .out_data(od_b), .out_idx(oi[1]), .out_last(ol[1]), .busy(bz[1]));
  extractor_stream #(.WIDTH(12), .LANES(5), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id),
    .out_valid(ov[2]), .out_ready(ordy), .out_data(od_c), .out_idx(oi[2]), .out_last(ol[2]), .busy(bz[2]));
  extractor_stream #(.WIDTH(12), .LANES(5), .MSB_FIRST(1'b1)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id),
    .out_valid(ov[3]), .out_ready(ordy), .out_data(od_d), .out_idx(oi[3]), .out_last(ol[3]), .busy(bz[3]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got %h expected %h", name, got, exp);
  endtask

  task automatic push(input int d, input logic last, input logic [1:0] idx, input logic [4:0] data);
    q[d].push_back({last, idx, data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < 20, 1);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ov[i] && ordy && !flush && !rst) begin
        if (q[i].size() == 0) chk($sformatf("unexpected_beat_dut%0d", i), {ol[i], oi[i], od[i]}, 8'hxx);
        else chk($sformatf("beat_dut%0d", i), {ol[i], oi[i], od[i]}, q[i].pop_front());
      end
    end
  end

  initial begin
    tick();
    chk("rst_in_ready", ir, 4'h0);
    chk("rst_out_valid", ov, 4'h0);
    chk("rst_busy", bz, 4'h0);
    chk("rst_out_last", ol, 4'h0);
    chk("rst_idx_data_b", {oi[1], od[1]}, 7'h00);
    chk("rst_idx_data_d", {oi[3], od[3]}, 7'h00);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", ir, 4'hF);
    // single word through all four variants
    ordy = 1'b1;
    id = 12'hA5C;
    iv = 4'hF;
    push(0, 0, 0, 5'h0C); push(0, 0, 1, 5'h05); push(0, 1, 2, 5'h0A);
    push(1, 0, 2, 5'h0A); push(1, 0, 1, 5'h05); push(1, 1, 0, 5'h0C);
    push(2, 0, 0, 5'h1C); push(2, 0, 1, 5'h12); push(2, 1, 2, 5'h02);
    push(3, 0, 2, 5'h02); push(3, 0, 1, 5'h12); push(3, 1, 0, 5'h1C);
    tick();
    iv = 4'h0;
    chk("latency_out_valid", ov, 4'hF);
    drain();
    chk("idle_after_word", ov, 4'h0);
    // back-to-back words, no bubble
    id = 12'h123;
    iv[0] = 1'b1;
    push(0, 0, 0, 5'h3); push(0, 0, 1, 5'h2); push(0, 1, 2, 5'h1);
    tick();
    id = 12'h456;
    push(0, 0, 0, 5'h6); push(0, 0, 1, 5'h5); push(0, 1, 2, 5'h4);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) iv[0] = 1'b0;
      chk($sformatf("b2b_valid_%0d", k), ov[0], 1'b1);
      chk($sformatf("b2b_in_ready_%0d", k), ir[0], k % 3 == 2);
      tick();
    end
    chk("b2b_idle", ov[0], 1'b0);
    drain();
    // backpressure on beat 1
    id = 12'hA5C;
    iv[0] = 1'b1;
    push(0, 0, 0, 5'h0C); push(0, 0, 1, 5'h05); push(0, 1, 2, 5'h0A);
    tick();
    iv[0] = 1'b0;
    tick();
    ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold_%0d", k), {ov[0], ir[0], oi[0], od[0]}, {1'b1, 1'b0, 2'd1, 5'h05});
      tick();
    end
    ordy = 1'b1;
    drain();
    // flush on beat 1, then a fresh word
    iv[0] = 1'b1;
    push(0, 0, 0, 5'h0C);
    tick();
    iv[0] = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", ir[0], 1'b0);
    tick();
    flush = 1'b0;
    chk("flush_out_valid", ov[0], 1'b0);
    id = 12'hFFF;
    iv[0] = 1'b1;
    push(0, 0, 0, 5'h0F); push(0, 0, 1, 5'h0F); push(0, 1, 2, 5'h0F);
    tick();
    iv[0] = 1'b0;
    drain();
    // asynchronous reset mid-word, then a fresh word
    id = 12'hA5C;
    iv[0] = 1'b1;
    push(0, 0, 0, 5'h0C);
    tick();
    iv[0] = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {ov[0], bz[0], ir[0]}, 3'b000);
    tick();
    rst = 1'b0;
    chk("rst_mid_after", ov[0], 1'b0);
    id = 12'hFFF;
    iv[0] = 1'b1;
    push(0, 0, 0, 5'h0F); push(0, 0, 1, 5'h0F); push(0, 1, 2, 5'h0F);
    tick();
    iv[0] = 1'b0;
    drain();
    tick();
    chk("final_idle", ov, 4'h0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/extractor_stream.md
# extractor_stream

Parametrised, sequential successor to the static bus-splitting extractors in the compressor datapath. It accepts a WIDTH-bit partial-product word over a valid/ready handshake and emits it as a stream of LANES-bit beats, LSB-chunk-first or MSB-chunk-first. Compressor stages can then consume a column group per cycle instead of needing all WIDTH wires at once. It sits between the partial-product register and the time-multiplexed compressor tree.

## Interface
- WIDTH, 12, input word width in bits (≥1)
- LANES, 4, bits per output beat (1 ≤ LANES ≤ WIDTH)
- MSB_FIRST, 0, 0 = chunk 0 (bits [LANES-1:0]) first; 1 = highest chunk first
- Derived: BEATS = ceil(WIDTH/LANES); IW = max(1, clog2(BEATS))

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous abort of the current word
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WIDTH  word to extract
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  LANES  current chunk
- out_idx  out  IW  chunk index of current beat (always the LSB-relative chunk number)
- out_last  out  1  current beat is the final beat of the word
- busy  out  1  a word is held (state SHIFT)

## Operation
- Chunk k = in_data[k*LANES +: LANES], for k = 0..BEATS-1.
  - If WIDTH mod LANES ≠ 0, the top chunk is zero-extended in its upper bits.
- Word register: captures in_data on input handshake (in_valid && in_ready).
- Beat counter: 0..BEATS-1, counts accepted beats.
- FSM:
  - IDLE: out_valid=0; in_ready=1. On input handshake, capture the word, clear the counter, go to SHIFT.
  - SHIFT: out_valid=1; out_data = chunk sel, where sel = cnt (MSB_FIRST=0) or BEATS-1-cnt (MSB_FIRST=1); out_idx = sel; out_last = (cnt == BEATS-1).
    - Output handshake (out_valid && out_ready) on a non-last beat: cnt += 1.
    - Output handshake on the last beat: if in_valid in the same cycle, capture the new word, clear cnt, stay in SHIFT; otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==SHIFT && out_last && out_ready). This is a combinational path from out_ready to in_ready and is required for zero-bubble streaming.
- out_valid, once asserted, stays high with stable out_data/out_idx/out_last until accepted. No retraction.
- flush (highest priority after rst): next state IDLE, cnt=0.
  - Any beat handshake in the flush cycle is discarded.
  - in_ready=0 while flush=1, so no word is accepted.
- BEATS==1 (LANES==WIDTH): every beat is last; the block degenerates to a one-entry pipeline register with full throughput.

## Timing
- Reset values: state IDLE, cnt 0, word register 0, out_valid 0, out_data 0, out_idx 0, out_last 0, busy 0. in_ready is 1 after reset is released; it is driven 0 while rst=1.
- rst asserted mid-word: the word is dropped immediately (asynchronous); no beat of it appears after release.
- Latency: word accepted at edge N → first beat valid in the cycle after edge N.
- Throughput with out_ready held high: one word per BEATS cycles, no idle cycle between words.
- Backpressure: with out_ready=0, the beat holds indefinitely and in_ready stays 0 in SHIFT.
- out_data/out_idx/out_last are registered or decoded purely from registered state. No input-to-output combinational path except out_ready→in_ready.

## Test plan
- WIDTH=12, LANES=4, MSB_FIRST=0, in_data=12'hA5C, out_ready=1 → beats 4'hC, 4'h5, 4'hA with idx 0, 1, 2; out_last only on 4'hA; first beat one cycle after acceptance.
- Same word with MSB_FIRST=1 → beats 4'hA, 4'h5, 4'hC with idx 2, 1, 0; last on 4'hC.
- WIDTH=12, LANES=5, MSB_FIRST=0, in_data=12'hA5C → 5'h1C, 5'h12, 5'h02. With MSB_FIRST=1 → 5'h02, 5'h12, 5'h1C.
- Back-to-back: 12'h123 then 12'h456 presented continuously, out_ready=1 → six consecutive valid beats 3, 2, 1, 6, 5, 4 with no gap; in_ready high only in the last-beat cycles and in the initial IDLE.
- Backpressure: out_ready=0 for 5 cycles on beat 1 of 12'hA5C → out_data stays 4'h5, in_ready stays 0; on release, the sequence completes unchanged.
- Flush on beat 1 and rst asserted mid-word in a separate run → out_valid=0 next cycle (flush) or immediately (rst). Next word 12'hFFF streams from idx 0 (4'hF ×3).
